// File: rtl/board_io_pkg.sv
// board_io_pkg: shared state encoding and sizes for the board input front end.
package board_io_pkg;
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } deb_state_t;
  localparam int DEBOUNCE_CYCLES_DEF = 500000;
  localparam int PRESS_CNT_W = 8;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer with a configurable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  logic r_sync;
  always_ff @(posedge clk) begin
    if (reset) {r_sync, r_meta} <= {2{RST_VAL}};
    else {r_sync, r_meta} <= {r_meta, i_d};
  end
  assign o_q = r_sync;
endmodule

// File: rtl/step_input_conditioner.sv
// step_input_conditioner: debounces the step key into a one-cycle strobe and captures the data bit with it.
module step_input_conditioner
  import board_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   key_n,
  input  logic                   w_raw,
  output logic                   step,
  output logic                   w_out,
  output logic                   held,
  output logic [PRESS_CNT_W-1:0] press_count
);
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cfg
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic w_key_s;
  logic w_w_s;
  deb_state_t r_state;
  deb_state_t w_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic w_fire;
  logic r_step;
  logic r_w_out;
  logic r_held;
  logic [PRESS_CNT_W-1:0] r_press_count;
  // Key idles released (high) so reset never looks like a press edge on the chain.
  sync_2ff #(.RST_VAL(1'b1)) u_key_sync (.clk(clk), .reset(reset), .i_d(key_n), .o_q(w_key_s));
  sync_2ff #(.RST_VAL(1'b0)) u_w_sync   (.clk(clk), .reset(reset), .i_d(w_raw), .o_q(w_w_s));
  always_comb begin
    w_nxt = r_state;
    w_cnt_nxt = r_cnt;
    w_fire = 1'b0;
    case (r_state)
      IDLE: begin
        w_nxt = w_key_s ? IDLE : PRESS_WAIT;
        w_cnt_nxt = w_key_s ? '0 : C_ONE;
      end
      PRESS_WAIT: begin
        w_fire = !w_key_s && (r_cnt == C_LAST);
        w_nxt = w_key_s ? IDLE : (w_fire ? HELD : PRESS_WAIT);
        w_cnt_nxt = w_key_s ? '0 : (w_fire ? r_cnt : r_cnt + C_ONE);
      end
      HELD: begin
        w_nxt = w_key_s ? RELEASE_WAIT : HELD;
        w_cnt_nxt = w_key_s ? C_ONE : r_cnt;
      end
      RELEASE_WAIT: begin
        w_nxt = !w_key_s ? HELD : ((r_cnt == C_LAST) ? IDLE : RELEASE_WAIT);
        w_cnt_nxt = (!w_key_s || (r_cnt == C_LAST)) ? '0 : r_cnt + C_ONE;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_step <= 1'b0;
      r_w_out <= 1'b0;
      r_held <= 1'b0;
      r_press_count <= '0;
    end else begin
      r_state <= w_nxt;
      r_cnt <= w_cnt_nxt;
      r_step <= w_fire;
      r_w_out <= w_fire ? w_w_s : r_w_out;
      r_held <= (w_nxt == HELD) || (w_nxt == RELEASE_WAIT);
      r_press_count <= r_press_count + PRESS_CNT_W'(w_fire);
    end
  end
  assign step = r_step;
  assign w_out = r_w_out;
  assign held = r_held;
  assign press_count = r_press_count;
endmodule

// File: tb/tb_step_input_conditioner.sv
// tb_step_input_conditioner: directed stimulus with a scoreboard of expected steps and level checks.
module tb_step_input_conditioner;
  typedef struct {
    int cyc;
    int sig;
    int val;
  } chk_t;
  typedef struct {
    int         cyc;
    logic       w;
    logic [7:0] cnt;
  } step_t;

  logic clk = 1'b0;
  logic reset;
  logic key_n;
  logic w_raw;
  logic step;
  logic w_out;
  logic held;
  logic [7:0] press_count;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int act;
  logic done = 1'b0;
  logic [7:0] exp_cnt;
  chk_t cq[$];
  step_t sq[$];
  step_t se;

  step_input_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .key_n(key_n), .w_raw(w_raw),
    .step(step), .w_out(w_out), .held(held), .press_count(press_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void ex(int off, int sig, int val);
    cq.push_back('{cyc + off, sig, val});
  endfunction

  function automatic void ex_step(int off, logic w, logic [7:0] c);
    sq.push_back('{cyc + off, w, c});
  endfunction

  function automatic int sig_val(int sig);
    case (sig)
      0: return int'(step);
      1: return int'(held);
      2: return int'(w_out);
      default: return int'(press_count);
    endcase
  endfunction

  function automatic string sig_name(int sig);
    case (sig)
      0: return "step";
      1: return "held";
      2: return "w_out";
      default: return "press_count";
    endcase
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: owns every comparison and the final summary.
  always @(negedge clk) begin
    if (step) begin
      n_chk++;
      if (sq.size() == 0) begin
        n_fail++;
        $display("FAIL step_unexpected cyc=%0d got step=1 want 0", cyc);
      end else begin
        se = sq.pop_front();
        if (cyc != se.cyc || w_out !== se.w || press_count !== se.cnt) begin
          n_fail++;
          $display("FAIL step cyc got %0d want %0d, w_out got %b want %b, press_count got %0d want %0d",
                   cyc, se.cyc, w_out, se.w, press_count, se.cnt);
        end
      end
    end
    if (sq.size() > 0 && sq[0].cyc < cyc) begin
      n_chk++;
      n_fail++;
      $display("FAIL step_missing want step at cyc %0d, none by cyc %0d", sq[0].cyc, cyc);
      void'(sq.pop_front());
    end
    for (int i = cq.size() - 1; i >= 0; i--) begin
      if (cq[i].cyc <= cyc) begin
        n_chk++;
        act = sig_val(cq[i].sig);
        if (cq[i].cyc != cyc || act != cq[i].val) begin
          n_fail++;
          $display("FAIL %s at cyc %0d got %0d want %0d", sig_name(cq[i].sig), cq[i].cyc, act, cq[i].val);
        end
        cq.delete(i);
      end
    end
    if (done) begin
      if (sq.size() != 0 || cq.size() != 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL drain got %0d steps and %0d checks pending want 0", sq.size(), cq.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
    end
  end

  initial begin
    int pb[7];
    int pr[7];
    pb = '{0, 0, 1, 0, 0, 0, 0};
    pr = '{1, 1, 0, 1, 1, 1, 1};
    reset = 1'b1;
    key_n = 1'b1;
    w_raw = 1'b0;
    exp_cnt = 8'd0;
    for (int s = 0; s < 4; s++) ex(3, s, 0);
    tick(3);
    reset = 1'b0;
    tick(2);
    // Clean press; w_raw drops just after the edge that samples it for the step
    w_raw = 1'b1;
    key_n = 1'b0;
    exp_cnt++;
    ex_step(6, 1'b1, exp_cnt);
    ex(5, 1, 0);
    ex(6, 1, 1);
    ex(7, 0, 0);
    ex(20, 1, 1);
    ex(20, 2, 1);
    ex(20, 3, 1);
    tick(4);
    w_raw = 1'b0;
    tick(16);
    key_n = 1'b1;
    ex(5, 1, 1);
    ex(6, 1, 0);
    tick(8);
    // Press bounce: only the run after the glitch counts
    exp_cnt++;
    ex_step(9, 1'b0, exp_cnt);
    ex(8, 1, 0);
    ex(9, 1, 1);
    for (int i = 0; i < 7; i++) begin
      key_n = pb[i][0];
      tick(1);
    end
    tick(10);
    // Release bounce: back to HELD without a step, then IDLE after 4 highs
    ex(3, 1, 1);
    ex(5, 1, 1);
    ex(8, 1, 1);
    ex(9, 1, 0);
    for (int i = 0; i < 7; i++) begin
      key_n = pr[i][0];
      tick(1);
    end
    tick(6);
    // Data capture: w_out holds across a mid-hold switch change
    exp_cnt++;
    key_n = 1'b0;
    ex_step(6, 1'b0, exp_cnt);
    tick(8);
    w_raw = 1'b1;
    ex(4, 2, 0);
    tick(4);
    key_n = 1'b1;
    ex(8, 2, 0);
    tick(8);
    exp_cnt++;
    key_n = 1'b0;
    ex_step(6, 1'b1, exp_cnt);
    ex(7, 2, 1);
    tick(8);
    key_n = 1'b1;
    tick(8);
    // Wrap: 256 presses bring the counter through 255->0 back to 4
    for (int i = 0; i < 256; i++) begin
      w_raw = i[0];
      key_n = 1'b0;
      exp_cnt++;
      ex_step(6, w_raw, exp_cnt);
      tick(8);
      key_n = 1'b1;
      tick(8);
    end
    ex(1, 3, 4);
    tick(2);
    // Reset on the edge the step would fire, key kept held afterwards
    key_n = 1'b0;
    tick(5);
    reset = 1'b1;
    ex(1, 0, 0);
    ex(1, 1, 0);
    ex(1, 3, 0);
    tick(1);
    reset = 1'b0;
    ex_step(6, 1'b1, 8'd1);
    ex(5, 1, 0);
    ex(6, 1, 1);
    ex(7, 3, 1);
    tick(10);
    key_n = 1'b1;
    tick(8);
    done = 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
